// File: rtl/voice_framer.sv
// voice_framer: buffers an audio sample stream and emits overlapping frames of
// FRAME = 2**FRAME_LOG2 samples, one frame start every HOP samples.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   sample_in       incoming sample, written when sample_valid is high
//   sample_valid    sample_in valid this cycle (back-to-back allowed)
//   win_index       window coefficient address of the sample emitted next cycle
//   frame_data      framed sample, one cycle after its win_index
//   frame_valid     frame_data valid
//   frame_start     marks frame sample 0
//   frame_end       marks frame sample FRAME-1
//   overrun         sticky: a frame trigger arrived while a frame was emitting
module voice_framer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAME_LOG2 = 10,
  parameter int unsigned HOP        = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_valid,
  output logic [FRAME_LOG2-1:0] win_index,
  output logic [DATA_W-1:0]     frame_data,
  output logic                  frame_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  overrun
);

  localparam int unsigned FRAME  = 1 << FRAME_LOG2;
  localparam int unsigned DEPTH  = 2 * FRAME;
  localparam int unsigned PTR_W  = FRAME_LOG2 + 1;
  localparam int unsigned FILL_W = FRAME_LOG2 + 1;
  localparam int unsigned HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  base;
  logic [FILL_W-1:0] fill;
  logic [HOP_W-1:0]  hop_cnt;

  logic              trig_c;
  logic              emit_c;
  logic              last_c;
  logic              load_c;
  logic              drop_c;
  logic [PTR_W-1:0]  rd_addr_c;
  logic [PTR_W-1:0]  new_base_c;

  // Trigger on the FRAME-th sample after reset, then on every hop wrap.
  assign trig_c = sample_valid &&
                  ((fill == FILL_W'(FRAME - 1)) ||
                   ((fill == FILL_W'(FRAME)) && (hop_cnt == HOP_W'(HOP - 1))));

  // (wr_ptr + 1 - FRAME) mod 2*FRAME, i.e. the oldest of the newest FRAME samples.
  assign new_base_c = wr_ptr + PTR_W'(FRAME + 1);
  assign rd_addr_c  = base + PTR_W'(win_index);

  // Sample storage; read and write addresses never collide within a frame.
  always_ff @(posedge clk) begin
    if (sample_valid) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  // Write pointer, fill and hop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      fill    <= '0;
      hop_cnt <= '0;
    end else if (sample_valid) begin
      wr_ptr  <= wr_ptr + PTR_W'(1);
      if (fill != FILL_W'(FRAME)) begin
        fill <= fill + FILL_W'(1);
      end
      hop_cnt <= (hop_cnt == HOP_W'(HOP - 1)) ? '0 : hop_cnt + HOP_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; a trigger on the last read keeps EMIT for the next frame.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trig_c) state_nxt = S_EMIT;
      S_EMIT:  if (last_c && !trig_c) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM decoded controls.
  always_comb begin
    emit_c = (state == S_EMIT);
    last_c = emit_c && (win_index == FRAME_LOG2'(FRAME - 1));
    load_c = trig_c && (!emit_c || last_c);
    drop_c = trig_c && emit_c && !last_c;
  end

  // Read side: frame base, read index and registered frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      base        <= '0;
      win_index   <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_valid <= emit_c;
      frame_start <= emit_c && (win_index == '0);
      frame_end   <= last_c;
      frame_data  <= emit_c ? mem[rd_addr_c] : '0;
      if (load_c) begin
        base      <= new_base_c;
        win_index <= '0;
      end else if (emit_c) begin
        win_index <= last_c ? '0 : win_index + FRAME_LOG2'(1);
      end
      if (drop_c) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_voice_framer.sv
// Scoreboard bench for voice_framer: a sample-history reference model predicts
// every framed output cycle; a monitor compares each cycle's outputs.
module tb_voice_framer;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FRAME_LOG2 = 10;
  localparam int unsigned HOP        = 512;
  localparam int unsigned FRAME      = 1 << FRAME_LOG2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DATA_W-1:0]     sample_in;
  logic                  sample_valid;
  logic [FRAME_LOG2-1:0] win_index;
  logic [DATA_W-1:0]     frame_data;
  logic                  frame_valid;
  logic                  frame_start;
  logic                  frame_end;
  logic                  overrun;

  voice_framer #(.DATA_W(DATA_W), .FRAME_LOG2(FRAME_LOG2), .HOP(HOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .win_index    (win_index),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint                cyc;
    logic [DATA_W-1:0]     data;
    bit                    st;
    bit                    en;
    logic [FRAME_LOG2-1:0] idx;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] hist[$];
  longint            cyc = 0;
  longint            busy_until = 0;
  int                n_acc = 0;
  bit                exp_overrun = 1'b0;
  bit                mon_en = 1'b0;
  int                checks = 0;
  int                failures = 0;
  logic [FRAME_LOG2-1:0] prev_win = '0;

  task automatic chk(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cycle=%0d %s", name, cyc, detail);
    end
  endtask

  // Reference model: frame = last FRAME accepted samples at each trigger;
  // a trigger is honoured only once the previous frame's reads are complete.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      n_acc = 0;
      hist.delete();
      sb.delete();
      busy_until = 0;
      exp_overrun = 1'b0;
    end else if (sample_valid) begin
      hist.push_back(sample_in);
      n_acc++;
      if (n_acc == FRAME || (n_acc > FRAME && (n_acc % HOP) == 0)) begin
        if (cyc >= busy_until) begin
          for (int k = 0; k < FRAME; k++) begin
            exp_t e;
            e.cyc  = cyc + 1 + k;
            e.data = hist[n_acc - FRAME + k];
            e.st   = (k == 0);
            e.en   = (k == FRAME - 1);
            e.idx  = FRAME_LOG2'(k);
            sb.push_back(e);
          end
          busy_until = cyc + FRAME;
        end else begin
          exp_overrun = 1'b1;
        end
      end
    end
  end

  // Monitor: compare DUT outputs every cycle against the scoreboard front.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_out",
            frame_valid === 1'b1 && frame_data === e.data && frame_start === e.st &&
            frame_end === e.en && prev_win === e.idx,
            $sformatf("got v=%b d=%0d s=%b e=%b widx=%0d exp v=1 d=%0d s=%b e=%b widx=%0d",
                      frame_valid, frame_data, frame_start, frame_end, prev_win,
                      e.data, e.st, e.en, e.idx));
      end else begin
        chk("idle_out",
            frame_valid === 1'b0 && frame_data === '0 && frame_start === 1'b0 &&
            frame_end === 1'b0 && win_index === '0,
            $sformatf("got v=%b d=%0d s=%b e=%b widx=%0d exp all 0",
                      frame_valid, frame_data, frame_start, frame_end, win_index));
      end
      chk("overrun", overrun === exp_overrun,
          $sformatf("got %b exp %b", overrun, exp_overrun));
    end
    prev_win = win_index;
  end

  task automatic cyc1(input bit v, input logic [DATA_W-1:0] d);
    sample_valid = v;
    sample_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1(1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic burst(input int n);
    repeat (n) cyc1(1'b1, DATA_W'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();
    idle(5);

    // One sample short of a frame: nothing may be emitted.
    for (int i = 0; i < FRAME - 1; i++) begin
      idle($urandom_range(0, 2));
      cyc1(1'b1, DATA_W'($urandom));
    end
    idle(1200);

    // Sparse ramp: three frames, the third crossing the buffer wrap.
    do_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle(15);
      cyc1(1'b1, DATA_W'(i));
    end
    idle(1100);

    // Back-to-back samples: mid-frame triggers dropped, overrun sticks.
    do_reset();
    burst(3 * FRAME);
    idle(1100);

    // Hop trigger lands on the final read: next frame follows with no gap.
    do_reset();
    burst(FRAME);
    for (int i = 0; i < HOP; i++) begin
      idle(1);
      cyc1(1'b1, DATA_W'($urandom));
    end
    idle(1100);

    // Reset mid-frame, then a fresh frame needs FRAME new samples.
    do_reset();
    burst(FRAME);
    idle(300);
    do_reset();
    burst(FRAME - 1);
    idle(50);
    burst(1);
    idle(1100);

    // Random gaps and data.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      idle($urandom_range(0, 3));
      cyc1(1'b1, DATA_W'($urandom));
    end
    idle(1100);

    chk("sb_drained", sb.size() == 0,
        $sformatf("got %0d pending exp 0", sb.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_framer.md
VOICE_FRAMER -- requirements
Module: voice_framer

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter FRAME_LOG2, default 10, log2 of frame length (FRAME = 1024).
REQ-003 Parameter HOP, default 512, new samples between frame starts (50% overlap).
REQ-004 clk  input  1  sole clock, all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sample_in  input  DATA_W  incoming audio sample.
REQ-007 sample_valid  input  1  sample_in is valid this cycle; may assert any cycle, including back-to-back.
REQ-008 win_index  output  FRAME_LOG2  window coefficient address for the sample emitted next cycle.
REQ-009 frame_data  output  DATA_W  framed sample, aligned one cycle after its win_index.
REQ-010 frame_valid  output  1  frame_data is valid this cycle.
REQ-011 frame_start  output  1  high with frame_valid for frame sample 0.
REQ-012 frame_end  output  1  high with frame_valid for frame sample FRAME-1.
REQ-013 overrun  output  1  sticky: a frame trigger was dropped.

Function
REQ-014 Storage SHALL be a circular buffer of 2*FRAME words with an 11-bit write pointer; each sample_valid writes sample_in at wr_ptr, and wr_ptr increments modulo 2*FRAME.
REQ-015 A fill counter SHALL count accepted samples, saturating at FRAME; a hop counter SHALL count samples modulo HOP.
REQ-016 Frame trigger SHALL occur on the cycle the FRAME-th sample is accepted after reset, and thereafter each time the hop counter wraps (every HOP samples).
REQ-017 On trigger, the frame base SHALL be latched as (wr_ptr_after_write - FRAME) mod 2*FRAME, so the frame holds the most recent FRAME samples, including the triggering sample.
REQ-018 FSM states: IDLE, EMIT. IDLE -> EMIT on trigger. EMIT -> IDLE after win_index FRAME-1 is issued.
REQ-019 In EMIT, one read SHALL issue per clock: cycle k (k = 0..FRAME-1) drives win_index = k and reads address base+k; frame_data, frame_valid, frame_start and frame_end for sample k SHALL appear at cycle k+1.
REQ-020 Frame emission SHALL be gap-free: FRAME consecutive frame_valid cycles per frame.
REQ-021 Writes during EMIT SHALL continue uninterrupted; they can never overwrite unread frame samples, because the buffer is 2*FRAME deep.
REQ-022 A trigger arriving while in EMIT SHALL be dropped, overrun SHALL set and remain set until rst, and the current frame SHALL complete unaffected.
REQ-023 A trigger on the same cycle EMIT finishes its last read SHALL start a new frame on the next cycle; it SHALL NOT be dropped.
REQ-024 When frame_valid is low, frame_data SHALL be 0, frame_start and frame_end SHALL be 0, and win_index SHALL be 0.
REQ-025 Sample values SHALL pass through bit-exact; no arithmetic is performed on data.

Reset
REQ-026 On rst: wr_ptr, fill and hop counters cleared, FSM to IDLE, all outputs 0, overrun cleared.
REQ-027 rst asserted mid-frame SHALL abort the frame immediately, with frame_valid 0 from the next cycle; the buffer need not be cleared, and a new first frame requires FRAME fresh samples.

Verification
REQ-028 Feed ramp 0,1,2,... with one sample per 20 clocks -> first frame after sample 1023 carries data 0..1023, win_index 0..1023 leading data by 1 cycle, and frame_start/frame_end on values 0 and 1023.
REQ-029 Continue the ramp -> second frame triggers at sample 1535 with data 512..1535; third frame triggers at sample 2047 with data 1024..2047, crossing the buffer wrap correctly; overrun stays 0.
REQ-030 Drive sample_valid every clock -> a trigger at 512 samples into EMIT is dropped and overrun = 1; frame content remains exactly the 1024 samples latched at its trigger.
REQ-031 Time a trigger to coincide with the final read of a frame -> the next frame starts on the following cycle with no gap and overrun = 0.
REQ-032 Assert rst at frame sample 300 -> frame_valid is 0 on the next cycle; the next frame appears only after 1024 new samples.
REQ-033 Only 1023 samples after reset -> frame_valid never asserts.
